// File: rtl/ipu_frame_ctrl_cxy_pkg.sv
// Shared definitions for the IPU frame controller: config layout, FSM encoding.
package ipu_pkg_cxy;

  localparam int CFG_W = 58;

  // Field positions within the 58-bit config word, MSB first
  localparam int H_MAX_LSB     = 49;  localparam int H_MAX_W     = 9;
  localparam int H_MIN_LSB     = 40;  localparam int H_MIN_W     = 9;
  localparam int S_MAX_LSB     = 33;  localparam int S_MAX_W     = 7;
  localparam int S_MIN_LSB     = 26;  localparam int S_MIN_W     = 7;
  localparam int V_MAX_LSB     = 20;  localparam int V_MAX_W     = 6;
  localparam int V_MIN_LSB     = 14;  localparam int V_MIN_W     = 6;
  localparam int P0_BORDER_LSB = 13;  localparam int P0_BORDER_W = 1;
  localparam int P0_TH_LSB     = 9;   localparam int P0_TH_W     = 4;
  localparam int P1_BORDER_LSB = 8;   localparam int P1_BORDER_W = 1;
  localparam int P1_TH_LSB     = 4;   localparam int P1_TH_W     = 4;
  localparam int RESIZE_TH_LSB = 0;   localparam int RESIZE_TH_W = 4;

  typedef struct packed {
    logic [8:0] h_max;
    logic [8:0] h_min;
    logic [6:0] s_max;
    logic [6:0] s_min;
    logic [5:0] v_max;
    logic [5:0] v_min;
    logic       p0_border;
    logic [3:0] p0_th;
    logic       p1_border;
    logic [3:0] p1_th;
    logic [3:0] resize_th;
  } cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  function automatic cfg_t unpack_cfg(input logic [CFG_W-1:0] raw);
    return cfg_t'(raw);
  endfunction

endpackage

// File: rtl/ipu_frame_ctrl_cxy_if.sv
// Host, camera, pipeline and centroid signals of the IPU frame controller.
interface ipu_frame_ctrl_cxy_if;
  import ipu_pkg_cxy::*;

  logic             START;
  logic             CONT;
  logic             ABORT;
  logic             CFG_WE;
  logic [CFG_W-1:0] CFG_IN;
  logic             CAM_VALID;
  logic             CAM_SOF;
  logic [11:0]      CAM_RGB;
  logic             RGB_VALID;
  logic [11:0]      RGB;
  logic [CFG_W-1:0] CFG_OUT;
  logic             SQUEEZE;
  logic             PIPE_RSTn;
  logic             PIPE_LAST_PIX;
  logic             CENTROID_VALID;
  logic [17:0]      CENTROID_H;
  logic [17:0]      CENTROID_V;
  logic [12:0]      CENTROID_SUM;
  logic [17:0]      RES_H;
  logic [17:0]      RES_V;
  logic [12:0]      RES_SUM;
  logic             RES_VALID;
  logic             BUSY;
  logic [15:0]      FRAME_CNT;
  logic             ERR_TIMEOUT;
  logic             ERR_SOF;

  modport slave (
    input  START, CONT, ABORT, CFG_WE, CFG_IN, CAM_VALID, CAM_SOF, CAM_RGB,
           PIPE_LAST_PIX, CENTROID_VALID, CENTROID_H, CENTROID_V, CENTROID_SUM,
    output RGB_VALID, RGB, CFG_OUT, SQUEEZE, PIPE_RSTn, RES_H, RES_V, RES_SUM,
           RES_VALID, BUSY, FRAME_CNT, ERR_TIMEOUT, ERR_SOF
  );

  modport master (
    output START, CONT, ABORT, CFG_WE, CFG_IN, CAM_VALID, CAM_SOF, CAM_RGB,
           PIPE_LAST_PIX, CENTROID_VALID, CENTROID_H, CENTROID_V, CENTROID_SUM,
    input  RGB_VALID, RGB, CFG_OUT, SQUEEZE, PIPE_RSTn, RES_H, RES_V, RES_SUM,
           RES_VALID, BUSY, FRAME_CNT, ERR_TIMEOUT, ERR_SOF
  );

endinterface

// File: rtl/ipu_frame_ctrl_cxy_cfg_shadow.sv
// Pending/active config pair: host writes land in pending, apply copies them to
// the active copy only if something was written since the last apply.
module ipu_cfg_shadow_cxy
  import ipu_pkg_cxy::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CFG_W-1:0] cfg_in,
  input  logic             apply,
  output logic [CFG_W-1:0] cfg_out
);

  logic [CFG_W-1:0] pending_q, pending_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic             dirty_q, dirty_d;

  // A write coinciding with apply stays pending for the following frame
  always_comb begin
    pending_d = cfg_we ? cfg_in : pending_q;
    dirty_d   = cfg_we | (dirty_q & ~apply);
    active_d  = (apply && dirty_q) ? pending_q : active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      active_q  <= '0;
      dirty_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      dirty_q   <= dirty_d;
    end
  end

  assign cfg_out = active_q;

endmodule

// File: rtl/ipu_frame_ctrl_cxy.sv
// Frame-level sequencer: admits one whole camera frame per run, drains the
// pipeline with SQUEEZE, captures the centroid, and handles watchdog/abort.
module ipu_frame_ctrl_cxy
  import ipu_pkg_cxy::*;
#(
  parameter int P_WIDTH  = 320,
  parameter int P_HEIGHT = 240,
  parameter int TIMEOUT  = 65535
) (
  input logic                  CLK,
  input logic                  RST,
  ipu_frame_ctrl_cxy_if.slave  bus
);

  localparam logic [16:0] PIX_TOTAL = 17'(P_WIDTH * P_HEIGHT);
  localparam int          TO_W      = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [16:0]       pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [1:0]        rcv_cnt_q, rcv_cnt_d;
  logic              pipe_rstn_q, pipe_rstn_d;
  logic              rgb_valid_q, rgb_valid_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              squeeze_q, squeeze_d;
  logic [17:0]       res_h_q, res_h_d;
  logic [17:0]       res_v_q, res_v_d;
  logic [12:0]       res_sum_q, res_sum_d;
  logic              res_valid_q, res_valid_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              err_to_q, err_to_d;
  logic              err_sof_q, err_sof_d;
  logic              rcv_trig;
  logic              cfg_apply;

  ipu_cfg_shadow_cxy u_cfg_shadow (
    .clk     (CLK),
    .rst     (RST),
    .cfg_we  (bus.CFG_WE),
    .cfg_in  (bus.CFG_IN),
    .apply   (cfg_apply),
    .cfg_out (bus.CFG_OUT)
  );

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    to_cnt_d    = '0;
    rgb_valid_d = 1'b0;
    rgb_d       = rgb_q;
    res_h_d     = res_h_q;
    res_v_d     = res_v_q;
    res_sum_d   = res_sum_q;
    res_valid_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_to_d    = err_to_q;
    err_sof_d   = err_sof_q;
    rcv_trig    = 1'b0;
    cfg_apply   = 1'b0;

    if (bus.ABORT) begin
      rcv_trig = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            state_d   = ST_ARM;
            err_to_d  = 1'b0;
            err_sof_d = 1'b0;
          end
        end
        // SOF is only accepted once the pipeline is out of its recovery reset
        ST_ARM: begin
          if (bus.CAM_VALID && bus.CAM_SOF && pipe_rstn_q) begin
            rgb_valid_d = 1'b1;
            rgb_d       = bus.CAM_RGB;
            pix_cnt_d   = 17'd1;
            cfg_apply   = 1'b1;
            state_d     = (PIX_TOTAL == 17'd1) ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.CAM_VALID) begin
            if (bus.CAM_SOF) begin
              err_sof_d = 1'b1;
              rcv_trig  = 1'b1;
              state_d   = ST_ARM;
            end else begin
              rgb_valid_d = 1'b1;
              rgb_d       = bus.CAM_RGB;
              pix_cnt_d   = pix_cnt_q + 17'd1;
              if (pix_cnt_d == PIX_TOTAL) state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (bus.PIPE_LAST_PIX) state_d = ST_RESULT;
        end
        ST_RESULT: begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (bus.CENTROID_VALID) begin
            res_h_d     = bus.CENTROID_H;
            res_v_d     = bus.CENTROID_V;
            res_sum_d   = bus.CENTROID_SUM;
            res_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = bus.CONT ? ST_ARM : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A centroid arriving on the expiry cycle still counts as a good result
      if ((state_q == ST_FLUSH || state_q == ST_RESULT) && !res_valid_d &&
          to_cnt_d == TO_W'(TIMEOUT)) begin
        err_to_d = 1'b1;
        rcv_trig = 1'b1;
        state_d  = ST_IDLE;
      end
    end

    if (rcv_trig) begin
      pix_cnt_d   = '0;
      to_cnt_d    = '0;
      rgb_valid_d = 1'b0;
    end

    rcv_cnt_d   = rcv_trig ? 2'd2 : ((rcv_cnt_q != 2'd0) ? rcv_cnt_q - 2'd1 : 2'd0);
    pipe_rstn_d = (rcv_cnt_d == 2'd0);
    squeeze_d   = (state_q == ST_FLUSH) && (state_d == ST_FLUSH);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rcv_cnt_q   <= '0;
      pipe_rstn_q <= 1'b0;
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
      squeeze_q   <= 1'b0;
      res_h_q     <= '0;
      res_v_q     <= '0;
      res_sum_q   <= '0;
      res_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      err_to_q    <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      pipe_rstn_q <= pipe_rstn_d;
      rgb_valid_q <= rgb_valid_d;
      rgb_q       <= rgb_d;
      squeeze_q   <= squeeze_d;
      res_h_q     <= res_h_d;
      res_v_q     <= res_v_d;
      res_sum_q   <= res_sum_d;
      res_valid_q <= res_valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_to_q    <= err_to_d;
      err_sof_q   <= err_sof_d;
    end
  end

  assign bus.RGB_VALID   = rgb_valid_q;
  assign bus.RGB         = rgb_q;
  assign bus.SQUEEZE     = squeeze_q;
  assign bus.PIPE_RSTn   = pipe_rstn_q;
  assign bus.RES_H       = res_h_q;
  assign bus.RES_V       = res_v_q;
  assign bus.RES_SUM     = res_sum_q;
  assign bus.RES_VALID   = res_valid_q;
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.FRAME_CNT   = frame_cnt_q;
  assign bus.ERR_TIMEOUT = err_to_q;
  assign bus.ERR_SOF     = err_sof_q;

endmodule

// File: tb/tb_ipu_frame_ctrl_cxy.sv
// Directed bench for ipu_frame_ctrl_cxy with a 4x3 frame and a 50-cycle watchdog.
module tb_ipu_frame_ctrl_cxy;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [57:0] cfg300;

  ipu_frame_ctrl_cxy_if bus ();

  ipu_frame_ctrl_cxy #(
    .P_WIDTH  (4),
    .P_HEIGHT (3),
    .TIMEOUT  (50)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each pixel must appear on RGB exactly one edge after it is presented
  task automatic send_pixels(input int n, input logic first_sof, input logic [11:0] base);
    for (int i = 0; i < n; i++) begin
      bus.CAM_VALID = 1'b1;
      bus.CAM_SOF   = first_sof && (i == 0);
      bus.CAM_RGB   = base + 12'(i);
      tick();
      bus.CAM_VALID = 1'b0;
      bus.CAM_SOF   = 1'b0;
      check_output("rgb_valid", 64'(bus.RGB_VALID), 64'd1);
      check_output("rgb_data", 64'(bus.RGB), 64'(base + 12'(i)));
    end
  endtask

  task automatic pulse_last_pix();
    bus.PIPE_LAST_PIX = 1'b1;
    tick();
    bus.PIPE_LAST_PIX = 1'b0;
  endtask

  task automatic pulse_centroid(input logic [17:0] h, input logic [17:0] v, input logic [12:0] s);
    bus.CENTROID_VALID = 1'b1;
    bus.CENTROID_H     = h;
    bus.CENTROID_V     = v;
    bus.CENTROID_SUM   = s;
    tick();
    bus.CENTROID_VALID = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cfg300     = '0;
    cfg300[57:49] = 9'd300;
    rst = 1'b1;
    bus.START = 1'b0; bus.CONT = 1'b0; bus.ABORT = 1'b0;
    bus.CFG_WE = 1'b0; bus.CFG_IN = '0;
    bus.CAM_VALID = 1'b0; bus.CAM_SOF = 1'b0; bus.CAM_RGB = '0;
    bus.PIPE_LAST_PIX = 1'b0; bus.CENTROID_VALID = 1'b0;
    bus.CENTROID_H = '0; bus.CENTROID_V = '0; bus.CENTROID_SUM = '0;

    // Reset state
    tick(); tick();
    check_output("rst_pipe_rstn", 64'(bus.PIPE_RSTn), 64'd0);
    check_output("rst_busy", 64'(bus.BUSY), 64'd0);
    check_output("rst_cfg_out", 64'(bus.CFG_OUT), 64'd0);
    check_output("rst_frame_cnt", 64'(bus.FRAME_CNT), 64'd0);
    check_output("rst_rgb_valid", 64'(bus.RGB_VALID), 64'd0);
    rst = 1'b0;
    tick();
    check_output("post_rst_pipe_rstn", 64'(bus.PIPE_RSTn), 64'd1);

    // START and ABORT together: abort wins, pipeline reset pulse
    bus.START = 1'b1; bus.ABORT = 1'b1;
    tick();
    bus.START = 1'b0; bus.ABORT = 1'b0;
    check_output("start_abort_busy", 64'(bus.BUSY), 64'd0);
    check_output("start_abort_rstn", 64'(bus.PIPE_RSTn), 64'd0);
    tick(); tick();
    check_output("start_abort_rstn_back", 64'(bus.PIPE_RSTn), 64'd1);

    // Frame 1: single run, config written mid-run stays pending
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_output("f1_busy", 64'(bus.BUSY), 64'd1);
    bus.CAM_VALID = 1'b1; bus.CAM_SOF = 1'b0; bus.CAM_RGB = 12'hABC;
    tick();
    bus.CAM_VALID = 1'b0;
    check_output("f1_arm_drop", 64'(bus.RGB_VALID), 64'd0);
    send_pixels(1, 1'b1, 12'h100);
    check_output("f1_cfg_sof", 64'(bus.CFG_OUT), 64'd0);
    send_pixels(2, 1'b0, 12'h101);
    bus.CFG_WE = 1'b1; bus.CFG_IN = cfg300;
    send_pixels(1, 1'b0, 12'h103);
    bus.CFG_WE = 1'b0;
    check_output("f1_cfg_hold", 64'(bus.CFG_OUT), 64'd0);
    send_pixels(8, 1'b0, 12'h104);
    check_output("f1_sq_not_yet", 64'(bus.SQUEEZE), 64'd0);
    tick();
    check_output("f1_sq_rise", 64'(bus.SQUEEZE), 64'd1);
    check_output("f1_flush_no_pix", 64'(bus.RGB_VALID), 64'd0);
    tick();
    check_output("f1_sq_hold", 64'(bus.SQUEEZE), 64'd1);
    pulse_last_pix();
    check_output("f1_sq_fall", 64'(bus.SQUEEZE), 64'd0);
    check_output("f1_result_busy", 64'(bus.BUSY), 64'd1);
    pulse_centroid(18'd100, 18'd50, 13'd7);
    check_output("f1_res_valid", 64'(bus.RES_VALID), 64'd1);
    check_output("f1_res_h", 64'(bus.RES_H), 64'd100);
    check_output("f1_res_v", 64'(bus.RES_V), 64'd50);
    check_output("f1_res_sum", 64'(bus.RES_SUM), 64'd7);
    check_output("f1_frame_cnt", 64'(bus.FRAME_CNT), 64'd1);
    check_output("f1_idle", 64'(bus.BUSY), 64'd0);
    tick();
    check_output("f1_res_valid_pulse", 64'(bus.RES_VALID), 64'd0);
    check_output("f1_cfg_idle", 64'(bus.CFG_OUT), 64'd0);

    // Continuous mode: two frames back to back, config applied at first SOF
    bus.CONT = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_output("fa_cfg_arm", 64'(bus.CFG_OUT), 64'd0);
    send_pixels(1, 1'b1, 12'h200);
    check_output("fa_cfg_applied", 64'(bus.CFG_OUT), 64'(cfg300));
    send_pixels(11, 1'b0, 12'h201);
    tick();
    pulse_last_pix();
    pulse_centroid(18'd1, 18'd2, 13'd3);
    check_output("fa_res_valid", 64'(bus.RES_VALID), 64'd1);
    check_output("fa_res_h", 64'(bus.RES_H), 64'd1);
    check_output("fa_frame_cnt", 64'(bus.FRAME_CNT), 64'd2);
    check_output("fa_busy", 64'(bus.BUSY), 64'd1);
    bus.CAM_VALID = 1'b1; bus.CAM_SOF = 1'b0; bus.CAM_RGB = 12'h555;
    tick();
    bus.CAM_VALID = 1'b0;
    check_output("gap_drop", 64'(bus.RGB_VALID), 64'd0);
    check_output("gap_busy", 64'(bus.BUSY), 64'd1);
    send_pixels(1, 1'b1, 12'h300);
    send_pixels(11, 1'b0, 12'h301);
    tick();
    pulse_last_pix();
    pulse_centroid(18'd4, 18'd5, 13'd6);
    check_output("fb_res_valid", 64'(bus.RES_VALID), 64'd1);
    check_output("fb_res_h", 64'(bus.RES_H), 64'd4);
    check_output("fb_res_v", 64'(bus.RES_V), 64'd5);
    check_output("fb_res_sum", 64'(bus.RES_SUM), 64'd6);
    check_output("fb_frame_cnt", 64'(bus.FRAME_CNT), 64'd3);
    check_output("fb_busy", 64'(bus.BUSY), 64'd1);
    bus.CONT = 1'b0;
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    check_output("arm_abort_busy", 64'(bus.BUSY), 64'd0);
    check_output("arm_abort_rstn", 64'(bus.PIPE_RSTn), 64'd0);
    check_output("arm_abort_res_h", 64'(bus.RES_H), 64'd4);
    tick(); tick();
    check_output("arm_abort_rstn_back", 64'(bus.PIPE_RSTn), 64'd1);

    // Early SOF at pixel 6: error, recovery, then a clean frame
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    send_pixels(1, 1'b1, 12'h400);
    send_pixels(5, 1'b0, 12'h401);
    bus.CAM_VALID = 1'b1; bus.CAM_SOF = 1'b1; bus.CAM_RGB = 12'h4FF;
    tick();
    bus.CAM_VALID = 1'b0; bus.CAM_SOF = 1'b0;
    check_output("sof_no_fwd", 64'(bus.RGB_VALID), 64'd0);
    check_output("sof_err", 64'(bus.ERR_SOF), 64'd1);
    check_output("sof_rstn_1", 64'(bus.PIPE_RSTn), 64'd0);
    check_output("sof_busy", 64'(bus.BUSY), 64'd1);
    tick();
    check_output("sof_rstn_2", 64'(bus.PIPE_RSTn), 64'd0);
    tick();
    check_output("sof_rstn_back", 64'(bus.PIPE_RSTn), 64'd1);
    send_pixels(1, 1'b1, 12'h500);
    send_pixels(11, 1'b0, 12'h501);
    tick();
    check_output("sof_clean_sq", 64'(bus.SQUEEZE), 64'd1);
    pulse_last_pix();
    pulse_centroid(18'd9, 18'd8, 13'd7);
    check_output("sof_clean_valid", 64'(bus.RES_VALID), 64'd1);
    check_output("sof_clean_cnt", 64'(bus.FRAME_CNT), 64'd4);
    check_output("sof_clean_idle", 64'(bus.BUSY), 64'd0);
    check_output("sof_err_sticky", 64'(bus.ERR_SOF), 64'd1);

    // Watchdog: no centroid, error 50 cycles after the last pixel appears
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_output("start_clears_sof", 64'(bus.ERR_SOF), 64'd0);
    send_pixels(1, 1'b1, 12'h600);
    send_pixels(11, 1'b0, 12'h601);
    repeat (49) tick();
    check_output("to_not_yet", 64'(bus.ERR_TIMEOUT), 64'd0);
    check_output("to_sq_high", 64'(bus.SQUEEZE), 64'd1);
    check_output("to_busy", 64'(bus.BUSY), 64'd1);
    tick();
    check_output("to_err", 64'(bus.ERR_TIMEOUT), 64'd1);
    check_output("to_idle", 64'(bus.BUSY), 64'd0);
    check_output("to_sq_low", 64'(bus.SQUEEZE), 64'd0);
    check_output("to_rstn_1", 64'(bus.PIPE_RSTn), 64'd0);
    check_output("to_no_res", 64'(bus.RES_VALID), 64'd0);
    tick();
    check_output("to_rstn_2", 64'(bus.PIPE_RSTn), 64'd0);
    tick();
    check_output("to_rstn_back", 64'(bus.PIPE_RSTn), 64'd1);
    check_output("to_frame_cnt", 64'(bus.FRAME_CNT), 64'd4);
    check_output("to_res_h", 64'(bus.RES_H), 64'd9);

    // Abort in the middle of FLUSH
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_output("start_clears_to", 64'(bus.ERR_TIMEOUT), 64'd0);
    send_pixels(1, 1'b1, 12'h700);
    send_pixels(11, 1'b0, 12'h701);
    tick(); tick();
    check_output("fl_sq", 64'(bus.SQUEEZE), 64'd1);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    check_output("fl_abort_sq", 64'(bus.SQUEEZE), 64'd0);
    check_output("fl_abort_idle", 64'(bus.BUSY), 64'd0);
    check_output("fl_abort_rstn", 64'(bus.PIPE_RSTn), 64'd0);
    check_output("fl_abort_no_res", 64'(bus.RES_VALID), 64'd0);
    check_output("fl_abort_cnt", 64'(bus.FRAME_CNT), 64'd4);
    tick(); tick();

    // Reset in the middle of RUN
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    send_pixels(1, 1'b1, 12'h800);
    send_pixels(3, 1'b0, 12'h801);
    check_output("mr_cfg", 64'(bus.CFG_OUT), 64'(cfg300));
    rst = 1'b1;
    tick();
    check_output("mr_rgb_valid", 64'(bus.RGB_VALID), 64'd0);
    check_output("mr_rgb", 64'(bus.RGB), 64'd0);
    check_output("mr_busy", 64'(bus.BUSY), 64'd0);
    check_output("mr_cfg_out", 64'(bus.CFG_OUT), 64'd0);
    check_output("mr_frame_cnt", 64'(bus.FRAME_CNT), 64'd0);
    check_output("mr_res_h", 64'(bus.RES_H), 64'd0);
    check_output("mr_res_sum", 64'(bus.RES_SUM), 64'd0);
    check_output("mr_pipe_rstn", 64'(bus.PIPE_RSTn), 64'd0);
    rst = 1'b0;
    tick();
    check_output("mr_pipe_rstn_back", 64'(bus.PIPE_RSTn), 64'd1);
    check_output("mr_idle", 64'(bus.BUSY), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
